// File: rtl/zapper_pkg.sv
// rtl/zapper_pkg.sv - shared state encoding and player-input word layout for the Zapper shot controller
package zapper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_BLANK    = 3'd2,
      ST_FLASH    = 3'd3,
      ST_REPORT   = 3'd4,
      ST_COOLDOWN = 3'd5
   } zapper_state_t;

   localparam int BIT_SHOT   = 0;
   localparam int BIT_HIT    = 1;
   localparam int BIT_TGT_LO = 2;
   localparam int BIT_TGT_HI = 3;
   localparam int BIT_CHEAT  = 4;

   // A cheating shot never reports a hit, even if one was latched.
   function automatic logic [15:0] pack_plyr(input logic cheat, input logic [1:0] tgt, input logic hit);
      logic [15:0] word;
      word                        = '0;
      word[BIT_SHOT]              = 1'b1;
      word[BIT_HIT]               = hit & ~cheat;
      word[BIT_TGT_HI:BIT_TGT_LO] = tgt;
      word[BIT_CHEAT]             = cheat;
      return word;
   endfunction

endpackage

// File: rtl/zapper_shot_ctrl_sync2.sv
// rtl/zapper_shot_ctrl_sync2.sv - two-flop synchronizer for the raw Zapper pins, reset to the pin's idle level
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/zapper_shot_ctrl.sv
// rtl/zapper_shot_ctrl.sv - sequences one Zapper shot: blank frame, per-target flash frames, result latch, cooldown
module zapper_shot_ctrl
   import zapper_pkg::*;
#(
   parameter int NUM_TGT_MAX     = 4,
   parameter int TGT_W           = 2,
   parameter int SETTLE_CYCLES   = 2000,
   parameter int COOLDOWN_CYCLES = 100000,
   parameter int CNT_W           = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trigger,
   input  logic             sensor,
   input  logic             frame_start,
   input  logic [TGT_W:0]   num_targets,
   output logic             blank_screen,
   output logic             target_en,
   output logic [TGT_W-1:0] target_sel,
   output logic             busy,
   output logic             done,
   output logic [15:0]      plyr_input
);

   zapper_state_t    state, state_nxt;
   logic             trig_s, trig_q, sens_s, pull;
   logic [CNT_W-1:0] cnt;
   logic [TGT_W:0]   ntgt, ntgt_in;
   logic [TGT_W-1:0] tgt, hit_tgt;
   logic             hit, cheat, settled, last_tgt, cool_done;

   sync2 #(.RST_VAL(1'b1)) u_trig_sync (.clk(clk), .rst(rst), .d(trigger), .q(trig_s));
   sync2 #(.RST_VAL(1'b0)) u_sens_sync (.clk(clk), .rst(rst), .d(sensor),  .q(sens_s));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) trig_q <= 1'b1;
      else      trig_q <= trig_s;
   end

   assign pull      = trig_q & ~trig_s;
   assign settled   = (cnt >= CNT_W'(SETTLE_CYCLES));
   assign cool_done = (cnt >= CNT_W'(COOLDOWN_CYCLES - 1));
   assign last_tgt  = ((TGT_W+1)'(tgt) == ntgt - (TGT_W+1)'(1));

   always_comb begin
      ntgt_in = num_targets;
      if (num_targets == '0)
         ntgt_in = (TGT_W+1)'(1);
      else if (num_targets > (TGT_W+1)'(NUM_TGT_MAX))
         ntgt_in = (TGT_W+1)'(NUM_TGT_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      busy         = (state != ST_IDLE);
      blank_screen = 1'b0;
      target_en    = 1'b0;
      target_sel   = '0;
      done         = 1'b0;
      case (state)
         ST_IDLE:     if (pull) state_nxt = ST_ARM;
         ST_ARM:      if (frame_start) state_nxt = ST_BLANK;
         ST_BLANK: begin
            blank_screen = 1'b1;
            if (frame_start) state_nxt = cheat ? ST_REPORT : ST_FLASH;
         end
         ST_FLASH: begin
            target_en  = 1'b1;
            target_sel = tgt;
            if (frame_start && (hit || last_tgt)) state_nxt = ST_REPORT;
         end
         ST_REPORT: begin
            done      = 1'b1;
            state_nxt = ST_COOLDOWN;
         end
         ST_COOLDOWN: if (cool_done && trig_s) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // One saturating counter serves both the per-frame settle window and the cooldown.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if ((state_nxt != state) || (state == ST_FLASH && frame_start))
         cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
         cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ntgt       <= '0;
         tgt        <= '0;
         hit        <= 1'b0;
         hit_tgt    <= '0;
         cheat      <= 1'b0;
         plyr_input <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pull) begin
                  ntgt       <= ntgt_in;
                  tgt        <= '0;
                  hit        <= 1'b0;
                  hit_tgt    <= '0;
                  cheat      <= 1'b0;
                  plyr_input <= '0;
               end
            end
            ST_BLANK: begin
               if (settled && sens_s) cheat <= 1'b1;
            end
            ST_FLASH: begin
               if (settled && sens_s && !hit) begin
                  hit     <= 1'b1;
                  hit_tgt <= tgt;
               end
               if (frame_start && !(hit || last_tgt)) tgt <= tgt + TGT_W'(1);
            end
            ST_REPORT: plyr_input <= pack_plyr(cheat, 2'(hit_tgt), hit);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_zapper_shot_ctrl.sv
// tb/tb_zapper_shot_ctrl.sv - self-checking bench for zapper_shot_ctrl with a frame-level shot model
module tb_zapper_shot_ctrl;

   localparam int SETTLE = 4;
   localparam int COOL   = 8;
   localparam int PERIOD = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trigger = 1'b1;
   logic        sensor = 1'b0;
   logic        frame_start = 1'b0;
   logic [2:0]  num_targets = 3'd1;
   logic        blank_screen, target_en, busy, done;
   logic [1:0]  target_sel;
   logic [15:0] plyr_input;

   int checks = 0;
   int failures = 0;

   int   phase = PERIOD - 1;
   int   fnum = 0;
   int   base_f = 1000000;
   logic [4:0] win_en = '0;
   int   win_lo[5];
   int   win_hi[5];
   logic [4:0] m_en;
   int   m_lo[5];
   int   m_hi[5];

   int   done_cnt = 0;
   int   done_f = 0;
   int   blank_cnt = 0;
   int   flash_q[$];
   int   viol_excl = 0;
   int   viol_timing = 0;
   logic pb = 1'b0;
   logic pt = 1'b0;

   zapper_shot_ctrl #(
      .NUM_TGT_MAX(4), .TGT_W(2), .SETTLE_CYCLES(SETTLE), .COOLDOWN_CYCLES(COOL), .CNT_W(17)
   ) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .sensor(sensor), .frame_start(frame_start),
      .num_targets(num_targets), .blank_screen(blank_screen), .target_en(target_en),
      .target_sel(target_sel), .busy(busy), .done(done), .plyr_input(plyr_input)
   );

   initial forever #5 clk = ~clk;

   // Frame generator, sensor driver and output monitor. Sensor windows are given in
   // synchronized-sensor time (settle counter value); the pin leads by two flops.
   initial begin : gen
      int rel;
      forever begin
         @(negedge clk);
         phase = (phase + 1) % PERIOD;
         if (phase == 0) fnum++;
         frame_start = (phase == 0);
         rel = fnum - base_f;
         sensor = 1'b0;
         if (rel >= 0 && rel < 5)
            if (win_en[rel] && phase >= win_lo[rel] - 1 && phase <= win_hi[rel] - 1)
               sensor = 1'b1;
         if (blank_screen && target_en) viol_excl++;
         if (rst && phase != 1 && (blank_screen !== pb || target_en !== pt)) viol_timing++;
         pb = blank_screen;
         pt = target_en;
         if (done) begin
            done_cnt++;
            done_f = fnum;
         end
         if (phase == 1 && target_en) flash_q.push_back(int'(target_sel));
         if (phase == 1 && blank_screen) blank_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL wait_idle: busy got %b expected 0 after %0d cycles", busy, n);
      end
   endtask

   task automatic start_shot(input int nt);
      wait_idle();
      for (int i = 0; i < PERIOD && phase != 5; i++) step();
      num_targets = 3'(nt);
      done_cnt    = 0;
      blank_cnt   = 0;
      flash_q.delete();
      base_f      = fnum + 1;
      trigger     = 1'b0;
   endtask

   task automatic do_shot(input string name, input int nt, input bit hold);
      int n, nfl, hit_t, bound;
      logic cheat, hit;
      logic [15:0] exp;
      n     = (nt == 0) ? 1 : (nt > 4) ? 4 : nt;
      cheat = m_en[0] && m_hi[0] >= SETTLE;
      hit   = 1'b0;
      hit_t = 0;
      nfl   = 0;
      if (!cheat)
         for (int k = 0; k < n; k++) begin
            nfl++;
            if (m_en[k+1] && m_hi[k+1] >= SETTLE) begin
               hit   = 1'b1;
               hit_t = k;
               break;
            end
         end
      exp = 16'h0001 | (hit ? 16'h0002 : 16'h0) | 16'(hit_t << 2) | (cheat ? 16'h0010 : 16'h0);

      start_shot(nt);
      win_en = m_en;
      win_lo = m_lo;
      win_hi = m_hi;
      repeat (4) step();
      checks++;
      if (busy !== 1'b1 || plyr_input !== 16'h0000) begin
         failures++;
         $display("FAIL %s pull_clear: busy=%b plyr_input=%h expected busy=1 plyr_input=0000", name, busy, plyr_input);
      end
      if (!hold) trigger = 1'b1;

      bound = 0;
      while (done_cnt == 0 && bound < 300) begin
         step();
         bound++;
      end
      checks++;
      if (done_cnt == 0) begin
         failures++;
         $display("FAIL %s done_seen: no done pulse within %0d cycles", name, bound);
      end
      repeat (2) step();

      checks++;
      if (plyr_input !== exp) begin
         failures++;
         $display("FAIL %s plyr_input: got %h expected %h", name, plyr_input, exp);
      end
      checks++;
      if (flash_q.size() != nfl) begin
         failures++;
         $display("FAIL %s flash_frames: got %0d expected %0d", name, flash_q.size(), nfl);
      end
      for (int k = 0; k < flash_q.size() && k < nfl; k++) begin
         checks++;
         if (flash_q[k] != k) begin
            failures++;
            $display("FAIL %s target_sel[%0d]: got %0d expected %0d", name, k, flash_q[k], k);
         end
      end
      checks++;
      if (blank_cnt != 1) begin
         failures++;
         $display("FAIL %s blank_frames: got %0d expected 1", name, blank_cnt);
      end
      checks++;
      if (done_f - base_f != 1 + nfl) begin
         failures++;
         $display("FAIL %s done_frame: got %0d expected %0d", name, done_f - base_f, 1 + nfl);
      end
      win_en = '0;
      if (!hold) begin
         wait_idle();
         checks++;
         if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
         end
      end
   endtask

   task automatic clear_model();
      m_en = '0;
      for (int i = 0; i < 5; i++) begin
         m_lo[i] = 1;
         m_hi[i] = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if ({busy, blank_screen, target_en, target_sel, done} !== 6'b0 || plyr_input !== 16'h0000) begin
         failures++;
         $display("FAIL reset_state: busy=%b blank=%b ten=%b sel=%0d done=%b plyr=%h expected all 0",
                  busy, blank_screen, target_en, target_sel, done, plyr_input);
      end
      rst = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_reset_mid_flash();
      int n = 0;
      clear_model();
      start_shot(4);
      repeat (4) step();
      trigger = 1'b1;
      while (target_en !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (target_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_flash_reach: target_en got %b expected 1", target_en);
      end
      repeat (3) step();
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, blank_screen, target_en, target_sel, done} !== 6'b0 || plyr_input !== 16'h0000) begin
         failures++;
         $display("FAIL rst_async: busy=%b ten=%b sel=%0d plyr=%h expected all 0", busy, target_en, target_sel, plyr_input);
      end
      repeat (3) step();
      rst = 1'b1;
      done_cnt = 0;
      repeat (60) step();
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_done: done_cnt=%0d busy=%b expected 0 and 0", done_cnt, busy);
      end
   endtask

   task automatic test_hit_third();
      clear_model();
      m_en[3] = 1'b1; m_lo[3] = 5; m_hi[3] = 10;
      do_shot("hit_third", 4, 1'b0);
   endtask

   task automatic test_miss_two();
      clear_model();
      do_shot("miss_two", 2, 1'b0);
   endtask

   task automatic test_cheat();
      clear_model();
      m_en[0] = 1'b1; m_lo[0] = 6; m_hi[0] = 17;
      m_en[1] = 1'b1; m_lo[1] = 6; m_hi[1] = 12;
      do_shot("cheat", 4, 1'b0);
   endtask

   task automatic test_settle_window();
      clear_model();
      m_en[1] = 1'b1; m_lo[1] = 1; m_hi[1] = 3;
      do_shot("settle_window", 1, 1'b0);
   endtask

   task automatic test_clamp();
      clear_model();
      do_shot("clamp_zero", 0, 1'b0);
      clear_model();
      m_en[4] = 1'b1; m_lo[4] = 4; m_hi[4] = 9;
      do_shot("clamp_high", 7, 1'b0);
   endtask

   task automatic test_hold_trigger();
      int n = 0;
      clear_model();
      m_en[1] = 1'b1; m_lo[1] = 6; m_hi[1] = 10;
      do_shot("hold", 2, 1'b1);
      repeat (20) step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL hold_no_rearm: busy got %b expected 1", busy);
      end
      trigger = 1'b1;
      while (busy !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL hold_release_idle: busy got %b expected 0", busy);
      end
      trigger = 1'b0;
      repeat (4) step();
      checks++;
      if (busy !== 1'b1 || plyr_input !== 16'h0000) begin
         failures++;
         $display("FAIL hold_repull: busy=%b plyr_input=%h expected 1 and 0000", busy, plyr_input);
      end
      trigger = 1'b1;
      wait_idle();
   endtask

   task automatic test_random();
      int nt, kind;
      for (int s = 0; s < 12; s++) begin
         clear_model();
         nt = $urandom_range(0, 7);
         for (int r = 0; r < 5; r++) begin
            kind = (r == 0) ? $urandom_range(0, 4) : $urandom_range(0, 2);
            if (kind == 1) begin
               m_en[r] = 1'b1;
               m_lo[r] = $urandom_range(1, 3);
               m_hi[r] = $urandom_range(m_lo[r], 3);
            end else if (kind == 2) begin
               m_en[r] = 1'b1;
               m_lo[r] = $urandom_range(1, 15);
               m_hi[r] = $urandom_range((m_lo[r] > SETTLE) ? m_lo[r] : SETTLE, 17);
            end
         end
         do_shot($sformatf("random%0d", s), nt, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_flash();
      test_hit_third();
      test_miss_two();
      test_cheat();
      test_settle_window();
      test_clamp();
      test_hold_trigger();
      test_random();
      checks++;
      if (viol_excl != 0) begin
         failures++;
         $display("FAIL exclusive_outputs: got %0d overlaps expected 0", viol_excl);
      end
      checks++;
      if (viol_timing != 0) begin
         failures++;
         $display("FAIL frame_aligned_outputs: got %0d off-boundary changes expected 0", viol_timing);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
